// File: rtl/core_int_ctl.sv
// core_int_ctl: prioritised interrupt controller feeding the core's BRK sequence.
// Sources are active-low, individually edge/level triggered and optionally
// maskable by the I flag. The lowest-index eligible source is latched on the
// rising edge of SYNC and held until the core acknowledges the vector fetch.
module core_int_ctl #(
  parameter int unsigned                  NUM_SRC   = 3,
  parameter logic [NUM_SRC-1:0]           EDGE_MODE = 3'b010,
  parameter logic [NUM_SRC-1:0]           MASKABLE  = 3'b100,
  parameter int unsigned                  RESET_SRC = 0,
  parameter logic [16*NUM_SRC-1:0]        VEC_TABLE = {16'hFFFE, 16'hFFFA, 16'hFFFC},
  parameter logic [15:0]                  BRK_VEC   = 16'hFFFE,
  parameter int unsigned                  SRC_W     = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
  input  logic               I_clock,
  input  logic               I_reset,
  input  logic               I_ready,
  input  logic [NUM_SRC-1:0] I_src_n,
  input  logic               I_iflag,
  input  logic               I_sync,
  input  logic               I_ack,
  output logic               O_pending,
  output logic               O_soft_brk,
  output logic [SRC_W-1:0]   O_src,
  output logic [15:0]        O_vec_lo,
  output logic [15:0]        O_vec_hi
);

  typedef enum logic {
    IDLE    = 1'b0,
    LATCHED = 1'b1
  } state_t;

  state_t             state, state_nx;
  logic [NUM_SRC-1:0] last_src;
  logic               last_sync;
  // Stored raise flags exist only for edge-mode sources; level sources are
  // read straight from the request lines.
  logic [NUM_SRC-1:0] edge_raise, edge_raise_nx;
  // The power-on raise of RESET_SRC is kept in its own flag so it survives
  // regardless of that source's mode and bypasses the I-flag mask.
  logic               rst_raise, rst_raise_nx;
  logic [SRC_W-1:0]   src_q, src_nx;
  logic [15:0]        vec_q, vec_nx;

  logic [NUM_SRC-1:0] elig;
  logic [NUM_SRC-1:0] new_edge;
  logic [NUM_SRC-1:0] win_hot;
  logic [SRC_W-1:0]   win;
  logic               win_ok;
  logic [15:0]        win_vec;
  logic               sync_rise;
  logic               free;

  // Eligibility, new-edge detection and fixed-priority pick (lowest index wins).
  always_comb begin
    elig     = '0;
    new_edge = '0;
    win_hot  = '0;
    win      = '0;
    win_ok   = 1'b0;
    win_vec  = BRK_VEC;
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      if (EDGE_MODE[i]) begin
        elig[i]     = edge_raise[i];
        new_edge[i] = last_src[i] & ~I_src_n[i];
      end else begin
        elig[i] = ~I_src_n[i];
      end
      if (MASKABLE[i] && I_iflag) begin
        elig[i] = 1'b0;
      end
      if ((i == RESET_SRC) && rst_raise) begin
        elig[i] = 1'b1;
      end
    end
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      if (elig[i] && !win_ok) begin
        win_ok     = 1'b1;
        win        = SRC_W'(i);
        win_hot[i] = 1'b1;
        win_vec    = VEC_TABLE[16*i +: 16];
      end
    end
  end

  // Next-state: ack frees the latch first, so a coincident sync_rise can
  // re-latch in the same cycle; fresh edges are OR-ed in last so they win
  // over a consume of the same index.
  always_comb begin
    state_nx      = state;
    src_nx        = src_q;
    vec_nx        = vec_q;
    edge_raise_nx = edge_raise;
    rst_raise_nx  = rst_raise;
    sync_rise     = I_sync & ~last_sync;
    free          = (state == IDLE) | I_ack;
    if ((state == LATCHED) && I_ack) begin
      state_nx = IDLE;
      src_nx   = '0;
      vec_nx   = BRK_VEC;
    end
    if (sync_rise && free && win_ok) begin
      state_nx      = LATCHED;
      src_nx        = win;
      vec_nx        = win_vec;
      edge_raise_nx = edge_raise & ~(win_hot & EDGE_MODE);
      rst_raise_nx  = rst_raise & ~win_hot[RESET_SRC];
    end
    edge_raise_nx = edge_raise_nx | new_edge;
  end

  // State and history registers; everything holds while I_ready is low.
  always_ff @(posedge I_clock) begin
    if (I_reset) begin
      state      <= IDLE;
      src_q      <= '0;
      vec_q      <= BRK_VEC;
      last_src   <= '1;
      last_sync  <= 1'b0;
      edge_raise <= '0;
      rst_raise  <= 1'b1;
    end else if (I_ready) begin
      state      <= state_nx;
      src_q      <= src_nx;
      vec_q      <= vec_nx;
      last_src   <= I_src_n;
      last_sync  <= I_sync;
      edge_raise <= edge_raise_nx;
      rst_raise  <= rst_raise_nx;
    end
  end

  assign O_pending  = (state == LATCHED);
  assign O_soft_brk = ~O_pending;
  assign O_src      = src_q;
  assign O_vec_lo   = vec_q;
  assign O_vec_hi   = vec_q + 16'd1;

endmodule

// File: tb/tb_core_int_ctl.sv
// tb_core_int_ctl: directed scenarios plus random traffic for core_int_ctl.
// A reference model updates once per clock and queues the expected outputs;
// a negedge monitor pops and compares them against the DUT.
module tb_core_int_ctl;

  logic        clk = 1'b0;
  logic        rst, ready, iflag, sync, ack;
  logic [2:0]  src_n;
  logic        pending, soft_brk;
  logic [1:0]  src;
  logic [15:0] vec_lo, vec_hi;

  always #5 clk = ~clk;

  core_int_ctl #(
    .NUM_SRC  (3),
    .EDGE_MODE(3'b010),
    .MASKABLE (3'b100),
    .RESET_SRC(0),
    .VEC_TABLE({16'hFFFE, 16'hFFFA, 16'hFFFC}),
    .BRK_VEC  (16'hFFFE)
  ) dut (
    .I_clock   (clk),
    .I_reset   (rst),
    .I_ready   (ready),
    .I_src_n   (src_n),
    .I_iflag   (iflag),
    .I_sync    (sync),
    .I_ack     (ack),
    .O_pending (pending),
    .O_soft_brk(soft_brk),
    .O_src     (src),
    .O_vec_lo  (vec_lo),
    .O_vec_hi  (vec_hi)
  );

  typedef struct {
    bit          pend;
    int          idx;
    logic [15:0] vec;
    string       tag;
  } exp_t;

  exp_t sbq[$];
  int   total = 0;
  int   bad   = 0;

  // Reference model state: pending edge requests, power-on request,
  // latched source (-1 = none), previous request lines and SYNC.
  bit          m_edge[3];
  bit          m_rst;
  int          m_lat;
  bit [2:0]    m_prev;
  bit          m_psync;
  bit [2:0]    edge_cfg = 3'b010;
  bit [2:0]    mask_cfg = 3'b100;
  logic [15:0] vecs[3]  = '{16'hFFFC, 16'hFFFA, 16'hFFFE};

  task automatic model_tick();
    bit srise;
    bit elig[3];
    bit newe[3];
    bit raised;
    int w;
    if (rst) begin
      m_edge  = '{default: 1'b0};
      m_rst   = 1'b1;
      m_lat   = -1;
      m_prev  = 3'b111;
      m_psync = 1'b0;
    end else if (ready) begin
      srise = sync && !m_psync;
      for (int i = 0; i < 3; i++) begin
        raised  = edge_cfg[i] ? m_edge[i] : !src_n[i];
        elig[i] = (raised && !(mask_cfg[i] && iflag)) || (i == 0 && m_rst);
        newe[i] = edge_cfg[i] && m_prev[i] && !src_n[i];
      end
      if (m_lat >= 0 && ack) m_lat = -1;
      if (srise && m_lat < 0) begin
        w = -1;
        for (int i = 0; i < 3; i++) if (elig[i] && w < 0) w = i;
        if (w >= 0) begin
          m_lat = w;
          if (edge_cfg[w]) m_edge[w] = 1'b0;
          if (w == 0) m_rst = 1'b0;
        end
      end
      for (int i = 0; i < 3; i++) if (newe[i]) m_edge[i] = 1'b1;
      m_prev  = src_n;
      m_psync = sync;
    end
  endtask

  task automatic push(input string tag);
    exp_t e;
    e.pend = (m_lat >= 0);
    e.idx  = (m_lat >= 0) ? m_lat : 0;
    e.vec  = (m_lat >= 0) ? vecs[m_lat] : 16'hFFFE;
    e.tag  = tag;
    sbq.push_back(e);
  endtask

  task automatic step(input string tag);
    @(posedge clk);
    model_tick();
    push(tag);
    #1;
  endtask

  task automatic sync_pulse(input string tag);
    sync = 1'b1;
    step(tag);
    sync = 1'b0;
    step(tag);
  endtask

  task automatic check(input string tag, input string name,
                       input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s/%s: got %0h want %0h", tag, name, act, want);
    end
  endtask

  // Monitor: compare whatever the DUT presents against the oldest expectation.
  always @(negedge clk) begin
    if (sbq.size() != 0) begin
      exp_t e;
      e = sbq.pop_front();
      check(e.tag, "pending",  32'(pending),  32'(e.pend));
      check(e.tag, "soft_brk", 32'(soft_brk), 32'(!e.pend));
      check(e.tag, "src",      32'(src),      32'(e.idx));
      check(e.tag, "vec_lo",   32'(vec_lo),   32'(e.vec));
      check(e.tag, "vec_hi",   32'(vec_hi),   32'(e.vec + 16'd1));
    end
  end

  initial begin
    rst = 1'b1; ready = 1'b1; iflag = 1'b0; sync = 1'b0; ack = 1'b0; src_n = 3'b111;
    step("reset");
    step("reset");
    rst = 1'b0;
    step("idle");

    // Power-on vector, then acknowledge back to software BRK.
    sync_pulse("s1_latch");
    step("s1_hold");
    ack = 1'b1; step("s1_ack"); ack = 1'b0;
    step("s1_idle");

    // Edge on src1 under I=1; level src2 is masked.
    iflag = 1'b1;
    src_n = 3'b101; step("s2_edge");
    src_n = 3'b001; step("s2_lvl");
    sync_pulse("s2_latch");
    ack = 1'b1; step("s2_ack"); ack = 1'b0;
    sync_pulse("s2_masked");

    // Priority src1 over src2, then src2, then nothing once released.
    iflag = 1'b0;
    src_n = 3'b111; step("s3_rel");
    src_n = 3'b001; step("s3_both");
    sync_pulse("s3_src1");
    ack = 1'b1; step("s3_ack1"); ack = 1'b0;
    sync_pulse("s3_src2");
    ack = 1'b1; step("s3_ack2"); ack = 1'b0;
    src_n = 3'b111; step("s3_rel2");
    sync_pulse("s3_none");

    // Edge hidden inside a stall is not seen; a later edge is.
    ready = 1'b0;
    src_n = 3'b101; step("s4_stall_fall");
    src_n = 3'b111; step("s4_stall_rise");
    ready = 1'b1;  step("s4_resume");
    sync_pulse("s4_none");
    src_n = 3'b101; step("s4_fall");
    sync_pulse("s4_src1");
    ack = 1'b1; step("s4_ack"); ack = 1'b0;

    // Coincident ack and sync_rise re-latch back to back.
    src_n = 3'b011; step("s5_src2");
    sync_pulse("s5_lat2");
    src_n = 3'b001; step("s5_edge1");
    sync = 1'b1; ack = 1'b1; step("s5_ackrise");
    sync = 1'b0; ack = 1'b0; step("s5_src1");
    ack = 1'b1; step("s5_ack"); ack = 1'b0;

    // Reset mid-service; power-on source wins afterwards.
    src_n = 3'b011; step("s6_lvl2");
    sync_pulse("s6_lat2");
    rst = 1'b1; step("s6_reset");
    rst = 1'b0; step("s6_post");
    sync_pulse("s6_src0");
    ack = 1'b1; step("s6_ack"); ack = 1'b0;

    // Random traffic.
    for (int n = 0; n < 3000; n++) begin
      rst   = ($urandom_range(0, 299) == 0);
      ready = ($urandom_range(0, 9) != 0);
      iflag = $urandom_range(0, 1);
      if ($urandom_range(0, 2) == 0) sync = ~sync;
      ack   = ((m_lat >= 0) && ($urandom_range(0, 3) == 0)) || ($urandom_range(0, 15) == 0);
      for (int b = 0; b < 3; b++) if ($urandom_range(0, 5) == 0) src_n[b] = ~src_n[b];
      step("rand");
    end
    rst = 1'b0; ack = 1'b0; ready = 1'b1;
    repeat (3) step("tail");

    for (int k = 0; k < 5 && sbq.size() != 0; k++) @(negedge clk);
    #1;
    total++;
    if (sbq.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d queued want 0", sbq.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
